// File: rtl/ucode_pipe_if.sv
// Bundle of sequencer-facing, control-store load and microword signals around
// the microprogram pipeline register.
interface ucode_pipe_if #(
    parameter int AW = 4,
    parameter int MW = 16
);
    logic [AW-1:0] y;
    logic [3:0]    cc;
    logic          hold;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [MW-1:0] ld_data;

    logic [MW-1:0] mi;
    logic          valid;
    logic [1:0]    s;
    logic          fe_;
    logic          pup;
    logic          re_;
    logic          zero_;
    logic          oe_;
    logic          cn;
    logic [AW-1:0] din;
    logic [AW-1:0] rin;
    logic [AW-1:0] orin;
    logic          cnt_zero;

    modport slave (
        input  y, cc, hold, ld_en, ld_addr, ld_data,
        output mi, valid, s, fe_, pup, re_, zero_, oe_, cn, din, rin, orin, cnt_zero
    );

    modport master (
        output y, cc, hold, ld_en, ld_addr, ld_data,
        input  mi, valid, s, fe_, pup, re_, zero_, oe_, cn, din, rin, orin, cnt_zero
    );
endinterface

// File: rtl/ucode_pipe.sv
// Writable control store, microword pipeline register and next-address decode
// driving a 2910-style sequencer slice.
module ucode_pipe #(
    parameter int AW = 4,
    parameter int MW = 16
) (
    input  logic          cp,
    input  logic          rst,
    ucode_pipe_if.slave   bus
);
    typedef enum logic [3:0] {
        OP_CONT     = 4'd0,
        OP_JMP_D    = 4'd1,
        OP_JSR_D    = 4'd2,
        OP_RTS      = 4'd3,
        OP_JMP_AR   = 4'd4,
        OP_LDAR     = 4'd5,
        OP_LSETUP   = 4'd6,
        OP_LOOP     = 4'd7,
        OP_RESTART  = 4'd8,
        OP_DISPATCH = 4'd9
    } op_e;

    logic [MW-1:0] store_q [2**AW];
    logic [MW-1:0] mi_q;
    logic          valid_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    op_e           op;
    logic [1:0]    ccsel;
    logic          pol;
    logic [AW-1:0] ba;
    logic          cond;

    assign op    = op_e'(mi_q[MW-1 -: 4]);
    assign ccsel = mi_q[MW-5 -: 2];
    assign pol   = mi_q[MW-7];
    assign ba    = mi_q[MW-8 -: AW];
    assign cond  = bus.cc[ccsel] ^ pol;

    // Control store is not reset; a separate block keeps it RAM-inferable.
    always_ff @(posedge cp) begin
        if (bus.ld_en) begin
            store_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q) begin
            if (op == OP_LSETUP && cond) begin
                cnt_d = ba;
            end else if (op == OP_LOOP && cnt_q != '0) begin
                cnt_d = cnt_q - AW'(1);
            end
        end
    end

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            mi_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else if (!bus.hold) begin
            mi_q    <= store_q[bus.y];
            valid_q <= 1'b1;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mi       = mi_q;
    assign bus.valid    = valid_q;
    assign bus.cnt_zero = (cnt_q == '0);
    assign bus.din      = ba;
    assign bus.rin      = ba;

    always_comb begin
        bus.s     = 2'b00;
        bus.fe_   = 1'b1;
        bus.pup   = 1'b0;
        bus.re_   = 1'b1;
        bus.zero_ = 1'b1;
        bus.oe_   = 1'b0;
        bus.cn    = 1'b1;
        bus.orin  = '0;
        if (!valid_q) begin
            bus.zero_ = 1'b0;
        end else if (bus.hold) begin
            // Reload uPC without increment so the stalled word is refetched.
            bus.cn = 1'b0;
        end else begin
            unique case (op)
                OP_JMP_D: if (cond) bus.s = 2'b11;
                OP_JSR_D: if (cond) begin
                    bus.s   = 2'b11;
                    bus.fe_ = 1'b0;
                    bus.pup = 1'b1;
                end
                OP_RTS: if (cond) begin
                    bus.s   = 2'b10;
                    bus.fe_ = 1'b0;
                end
                OP_JMP_AR: if (cond) bus.s = 2'b01;
                OP_LDAR:   if (cond) bus.re_ = 1'b0;
                OP_LSETUP: if (cond) begin
                    bus.fe_ = 1'b0;
                    bus.pup = 1'b1;
                end
                OP_LOOP: begin
                    if (cnt_q != '0) begin
                        bus.s = 2'b10;
                    end else begin
                        bus.fe_ = 1'b0;
                    end
                end
                OP_RESTART: if (cond) bus.zero_ = 1'b0;
                OP_DISPATCH: if (cond) begin
                    bus.s         = 2'b11;
                    bus.orin[3:0] = bus.cc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ucode_pipe.sv
// Random and directed stimulus for ucode_pipe, compared against a behavioural
// model of the control store, pipeline register and loop counter.
module tb_ucode_pipe;
    localparam int AW = 4;
    localparam int MW = 16;

    logic cp;
    logic rst;
    int   checks;
    int   errors;
    int   txn;

    logic [MW-1:0] m_store [16];
    logic [MW-1:0] m_mi;
    logic          m_valid;
    logic [3:0]    m_cnt;

    ucode_pipe_if #(.AW(AW), .MW(MW)) bus ();

    ucode_pipe #(.AW(AW), .MW(MW)) dut (
        .cp  (cp),
        .rst (rst),
        .bus (bus)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    wire [20:0] dut_ctl = {bus.s, bus.fe_, bus.pup, bus.re_, bus.zero_, bus.oe_, bus.cn,
                           bus.din, bus.rin, bus.orin, bus.cnt_zero};

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mkw(input int op, input int ccsel, input int pol,
                                        input int ba, input int user);
        logic [15:0] w;
        w = {op[3:0], ccsel[1:0], pol[0], ba[3:0], user[4:0]};
        return w;
    endfunction

    // Expected sequencer drive from the microword semantics table.
    function automatic logic [20:0] exp_ctl(input logic [15:0] w, input logic v,
                                            input logic [3:0] c, input logic [3:0] ccv,
                                            input logic h);
        logic [1:0] s;
        logic fe, pup, re, zero, oe, cn, cond;
        logic [3:0] orin, ba, op;
        s = 2'b00; fe = 1; pup = 0; re = 1; zero = 1; oe = 0; cn = 1; orin = 0;
        op   = w[15:12];
        ba   = w[8:5];
        cond = ccv[w[11:10]] ^ w[9];
        if (!v) zero = 0;
        else if (h) cn = 0;
        else if (op == 7) begin
            if (c != 0) s = 2'b10;
            else fe = 0;
        end else if (cond) begin
            case (op)
                1: s = 2'b11;
                2: begin s = 2'b11; fe = 0; pup = 1; end
                3: begin s = 2'b10; fe = 0; end
                4: s = 2'b01;
                5: re = 0;
                6: begin fe = 0; pup = 1; end
                8: zero = 0;
                9: begin s = 2'b11; orin = ccv; end
                default: ;
            endcase
        end
        return {s, fe, pup, re, zero, oe, cn, ba, ba, orin, (c == 0)};
    endfunction

    task automatic drive(input logic [3:0] yv, input logic [3:0] ccv, input logic hv,
                         input logic le, input logic [3:0] la, input logic [15:0] ld);
        bus.y = yv; bus.cc = ccv; bus.hold = hv;
        bus.ld_en = le; bus.ld_addr = la; bus.ld_data = ld;
        #1;
    endtask

    task automatic step(input logic [3:0] yv, input logic [3:0] ccv, input logic hv,
                        input logic le, input logic [3:0] la, input logic [15:0] ld);
        logic [3:0] op, ba;
        logic cond;
        drive(yv, ccv, hv, le, la, ld);
        check_eq("ctl", 64'(dut_ctl), 64'(exp_ctl(m_mi, m_valid, m_cnt, ccv, hv)));
        check_eq("mi", 64'(bus.mi), 64'(m_mi));
        check_eq("valid", 64'(bus.valid), 64'(m_valid));
        $display("txn %0d y=%h cc=%h hold=%b ld=%b@%h mi=%h valid=%b s=%b",
                 txn, yv, ccv, hv, le, la, bus.mi, bus.valid, bus.s);
        txn++;
        @(posedge cp);
        if (!rst && !hv) begin
            op = m_mi[15:12]; ba = m_mi[8:5]; cond = ccv[m_mi[11:10]] ^ m_mi[9];
            if (m_valid && op == 6 && cond) m_cnt = ba;
            else if (m_valid && op == 7 && m_cnt != 0) m_cnt = m_cnt - 1;
            m_mi    = m_store[yv];
            m_valid = 1'b1;
        end
        if (le) m_store[la] = ld;
        @(negedge cp);
    endtask

    task automatic load(input logic [3:0] a, input logic [15:0] w);
        step(4'h0, 4'h0, 1'b1, 1'b1, a, w);
    endtask

    task automatic reset_pulse();
        bus.ld_en = 1'b0;
        rst = 1'b1;
        #1;
        m_mi = '0; m_valid = 1'b0; m_cnt = '0;
        check_eq("rst_mi", 64'(bus.mi), 64'h0);
        check_eq("rst_valid", 64'(bus.valid), 64'h0);
        check_eq("rst_zero_", 64'(bus.zero_), 64'h0);
        check_eq("rst_cnt_zero", 64'(bus.cnt_zero), 64'h1);
        @(posedge cp);
        @(negedge cp);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; txn = 0;
        m_mi = '0; m_valid = 1'b0; m_cnt = '0;
        rst = 1'b1;
        bus.y = '0; bus.cc = '0; bus.hold = 1'b0;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        repeat (2) @(negedge cp);
        check_eq("init_mi", 64'(bus.mi), 64'h0);
        check_eq("init_valid", 64'(bus.valid), 64'h0);
        check_eq("init_zero_", 64'(bus.zero_), 64'h0);
        check_eq("init_cnt_zero", 64'(bus.cnt_zero), 64'h1);

        // Fill the store during reset; entry 0 is a CONT word.
        for (int a = 0; a < 16; a++) begin
            step(4'h0, 4'h0, 1'b0, 1'b1, 4'(a),
                 (a == 0) ? mkw(0, 0, 0, 5, 3) : 16'($urandom));
        end
        rst = 1'b0;
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("r39_zero_pre", 64'(bus.zero_), 64'h0);
        step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("r39_valid", 64'(bus.valid), 64'h1);
        check_eq("r39_mi", 64'(bus.mi), 64'(mkw(0, 0, 0, 5, 3)));
        check_eq("r39_s", 64'(bus.s), 64'h0);
        check_eq("r39_zero_", 64'(bus.zero_), 64'h1);

        // JSR D on cc[2]
        load(4'h3, mkw(2, 2, 0, 9, 0));
        step(4'h3, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        drive(4'h0, 4'b0100, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("jsr_s", 64'(bus.s), 64'h3);
        check_eq("jsr_fe_", 64'(bus.fe_), 64'h0);
        check_eq("jsr_pup", 64'(bus.pup), 64'h1);
        check_eq("jsr_din", 64'(bus.din), 64'h9);
        drive(4'h0, 4'b1011, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("jsr_nc_s", 64'(bus.s), 64'h0);
        check_eq("jsr_nc_fe_", 64'(bus.fe_), 64'h1);

        // Loop setup with count 2, then LOOP until exhausted
        load(4'h4, mkw(6, 0, 1, 2, 0));
        load(4'h5, mkw(7, 0, 0, 0, 0));
        step(4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        step(4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        for (int p = 0; p < 2; p++) begin
            drive(4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
            check_eq("loop_s", 64'(bus.s), 64'h2);
            check_eq("loop_cnt_zero", 64'(bus.cnt_zero), 64'h0);
            step(4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        end
        drive(4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("loop_end_s", 64'(bus.s), 64'h0);
        check_eq("loop_end_fe_", 64'(bus.fe_), 64'h0);
        check_eq("loop_end_pup", 64'(bus.pup), 64'h0);
        check_eq("loop_end_cz", 64'(bus.cnt_zero), 64'h1);
        step(4'h5, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("loop_nowrap", 64'(bus.cnt_zero), 64'h1);

        // Hold over JMP D
        load(4'h6, mkw(1, 0, 1, 12, 0));
        step(4'h6, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            drive(4'h7, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0);
            check_eq("hold_s", 64'(bus.s), 64'h0);
            check_eq("hold_cn", 64'(bus.cn), 64'h0);
            check_eq("hold_mi", 64'(bus.mi), 64'(mkw(1, 0, 1, 12, 0)));
            step(4'h7, 4'h0, 1'b1, 1'b0, 4'h0, 16'h0);
        end
        drive(4'h7, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("hold_rel_s", 64'(bus.s), 64'h3);
        check_eq("hold_rel_cn", 64'(bus.cn), 64'h1);

        // Read-before-write on the fetched address
        load(4'h8, 16'h0ABC);
        step(4'h8, 4'h0, 1'b0, 1'b1, 4'h8, 16'h0123);
        drive(4'h8, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("rbw_old", 64'(bus.mi), 64'h0ABC);
        step(4'h8, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        drive(4'h8, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("rbw_new", 64'(bus.mi), 64'h0123);

        // DISPATCH, then an unused opcode
        load(4'h9, mkw(9, 0, 0, 0, 0));
        load(4'hA, mkw(12, 3, 1, 7, 0));
        step(4'h9, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        drive(4'hA, 4'b0101, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("disp_s", 64'(bus.s), 64'h3);
        check_eq("disp_orin", 64'(bus.orin), 64'h5);
        step(4'hA, 4'b0101, 1'b0, 1'b0, 4'h0, 16'h0);
        drive(4'hA, 4'b0101, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("op12_ctl", 64'(dut_ctl),
                 64'({2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h7, 4'h7, 4'h0, 1'b1}));

        // Reset mid-loop abandons the count and restarts from address 0
        load(4'hB, mkw(6, 0, 1, 5, 0));
        load(4'hC, mkw(7, 0, 0, 0, 0));
        step(4'hB, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        step(4'hC, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        step(4'hC, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        reset_pulse();
        step(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        drive(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 16'h0);
        check_eq("rst_loop_mi", 64'(bus.mi), 64'(m_store[0]));
        check_eq("rst_loop_cz", 64'(bus.cnt_zero), 64'h1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(59) == 0) begin
                reset_pulse();
            end else begin
                step(4'($urandom), 4'($urandom), ($urandom_range(3) == 0),
                     ($urandom_range(2) == 0), 4'($urandom),
                     {4'($urandom_range(11)), 12'($urandom)});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
